// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register address type and the
// architectural zero register.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file_if.sv
// Register file access bundle between the ID/WB stages (master) and the
// register file (slave).
// There is no valid/ready handshake on this bundle: reads are combinational
// and always valid, and a write is taken on every rising clock edge where
// regwrite is high, with no back-pressure.
interface register_file_if;
    import cpu_pkg::*;

    reg_addr_t readreg1;
    reg_addr_t readreg2;
    reg_addr_t writereg;
    word_t     writeda;
    logic      regwrite;
    word_t     readda1;
    word_t     readda2;

    modport master (
        output readreg1, readreg2, writereg, writeda, regwrite,
        input  readda1, readda2
    );

    modport slave (
        input  readreg1, readreg2, writereg, writeda, regwrite,
        output readda1, readda2
    );

endinterface

// File: rtl/register_file_read_port.sv
// One combinational read port: zero register, then same-cycle bypass of the
// WB write, then the stored entry.
module register_file_read_port
    import cpu_pkg::*;
(
    input  reg_addr_t addr,
    input  reg_addr_t wr_addr,
    input  word_t     wr_data,
    input  logic      wr_en,
    input  word_t     entry,
    output word_t     data
);

    // Priority read mux; address 0 never forwards.
    always_comb begin
        data = entry;
        if (addr == REG_ZERO) begin
            data = '0;
        end else if (wr_en && (wr_addr == addr)) begin
            data = wr_data;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32 general-purpose register file for the ID stage: two combinational
// read ports with WB bypass, one synchronous write port, r0 hardwired to 0.
module register_file #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    register_file_if.slave         rf
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [0:NUM_REGS-1];

    // Forwarding is suppressed during reset so reads stay 0 while rst_n is low.
    logic bypass_en;
    assign bypass_en = rf.regwrite & rst_n;

    // Storage: asynchronous clear, writes to r0 dropped so entry 0 stays 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.regwrite && (rf.writereg != cpu_pkg::REG_ZERO)) begin
            regs[rf.writereg] <= rf.writeda;
        end
    end

    register_file_read_port u_port1 (
        .addr    (rf.readreg1),
        .wr_addr (rf.writereg),
        .wr_data (rf.writeda),
        .wr_en   (bypass_en),
        .entry   (regs[rf.readreg1]),
        .data    (rf.readda1)
    );

    register_file_read_port u_port2 (
        .addr    (rf.readreg2),
        .wr_addr (rf.writereg),
        .wr_data (rf.writeda),
        .wr_en   (bypass_en),
        .entry   (regs[rf.readreg2]),
        .data    (rf.readda2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed sequences, a vector table
// and randomized traffic against an array model of the architectural state.
module tb_register_file;

    logic clk;
    logic rst_n;

    register_file_if rf ();

    register_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf)
    );

    // 100 ns clock period
    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Architectural state model
    logic [31:0] model [0:31];

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        we;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected read value from the model and the current inputs
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0 || !rst_n) return 32'd0;
        if (rf.regwrite && rf.writereg == a) return rf.writeda;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    // One rising edge; model commits the write, then return on the falling edge
    task automatic tick();
        @(posedge clk);
        if (rst_n && rf.regwrite && rf.writereg != 5'd0) model[rf.writereg] = rf.writeda;
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] rr1, input logic [4:0] rr2,
                         input logic [4:0] wr, input logic [31:0] wd, input logic we);
        rf.readreg1 = rr1;
        rf.readreg2 = rr2;
        rf.writereg = wr;
        rf.writeda  = wd;
        rf.regwrite = we;
    endtask

    initial begin
        clear_model();
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 32'd0, 1'b0);

        // Reset: every address reads 0 on both ports
        #10;
        for (int i = 0; i < 32; i++) begin
            rf.readreg1 = 5'(i);
            rf.readreg2 = 5'(31 - i);
            #1;
            check("reset_rd1", rf.readda1, 32'd0);
            check("reset_rd2", rf.readda2, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read
        drive(5'd1, 5'd3, 5'd6, 32'd5, 1'b1);
        #1;
        check("basic_rd1_t0", rf.readda1, 32'd0);
        check("basic_rd2_t0", rf.readda2, 32'd0);
        tick();
        check("basic_rd1_t1", rf.readda1, 32'd0);
        check("basic_rd2_t1", rf.readda2, 32'd0);
        tick();
        check("basic_rd1_t2", rf.readda1, 32'd0);
        check("basic_rd2_t2", rf.readda2, 32'd0);
        rf.regwrite = 1'b0;
        rf.readreg1 = 5'd6;
        #1;
        check("basic_rd6", rf.readda1, 32'd5);

        // Zero register: write discarded, no forwarding
        drive(5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 1'b1);
        #1;
        check("zero_before", rf.readda1, 32'd0);
        tick();
        check("zero_after", rf.readda1, 32'd0);
        rf.regwrite = 1'b0;
        #1;
        check("zero_after_we0", rf.readda1, 32'd0);

        // Bypass on both ports
        drive(5'd0, 5'd0, 5'd7, 32'h11, 1'b1);
        tick();
        drive(5'd7, 5'd7, 5'd7, 32'h22, 1'b1);
        #1;
        check("bypass_rd1", rf.readda1, 32'h22);
        check("bypass_rd2", rf.readda2, 32'h22);
        tick();
        rf.regwrite = 1'b0;
        #1;
        check("bypass_rd1_post", rf.readda1, 32'h22);
        check("bypass_rd2_post", rf.readda2, 32'h22);

        // Write disable
        drive(5'd0, 5'd0, 5'd9, 32'hFF, 1'b0);
        tick();
        tick();
        tick();
        rf.readreg2 = 5'd9;
        #1;
        check("wdis_rd9", rf.readda2, 32'd0);

        // Vector table (state: r6=5, r7=0x22, r9=0); no clock edges
        tbl[0] = '{rr1: 5'd6,  rr2: 5'd7, wr: 5'd0, wd: 32'h0,        we: 1'b0, e1: 32'd5,  e2: 32'h22};
        tbl[1] = '{rr1: 5'd7,  rr2: 5'd6, wr: 5'd6, wd: 32'hAB,       we: 1'b1, e1: 32'h22, e2: 32'hAB};
        tbl[2] = '{rr1: 5'd0,  rr2: 5'd0, wr: 5'd0, wd: 32'hDEADBEEF, we: 1'b1, e1: 32'd0,  e2: 32'd0};
        tbl[3] = '{rr1: 5'd9,  rr2: 5'd9, wr: 5'd9, wd: 32'h99,       we: 1'b1, e1: 32'h99, e2: 32'h99};
        tbl[4] = '{rr1: 5'd31, rr2: 5'd1, wr: 5'd0, wd: 32'h0,        we: 1'b0, e1: 32'd0,  e2: 32'd0};
        tbl[5] = '{rr1: 5'd7,  rr2: 5'd0, wr: 5'd7, wd: 32'h33,       we: 1'b1, e1: 32'h33, e2: 32'd0};
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].rr1, tbl[i].rr2, tbl[i].wr, tbl[i].wd, tbl[i].we);
            #1;
            check($sformatf("tbl%0d_rd1", i), rf.readda1, tbl[i].e1);
            check($sformatf("tbl%0d_rd2", i), rf.readda2, tbl[i].e2);
        end
        rf.regwrite = 1'b0;

        // Full sweep: reg[i] = i*4+1
        for (int i = 1; i < 32; i++) begin
            drive(5'd0, 5'd0, 5'(i), 32'(i * 4 + 1), 1'b1);
            tick();
        end
        rf.regwrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rf.readreg1 = 5'(i);
            rf.readreg2 = 5'(i);
            #1;
            check($sformatf("sweep_rd1_%0d", i), rf.readda1, (i == 0) ? 32'd0 : 32'(i * 4 + 1));
            check($sformatf("sweep_rd2_%0d", i), rf.readda2, (i == 0) ? 32'd0 : 32'(i * 4 + 1));
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a1;
            logic [4:0] a2;
            logic [4:0] w;
            a1 = 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            w  = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
            drive(a1, a2, w, $urandom, 1'($urandom_range(0, 1)));
            #1;
            check("rand_rd1", rf.readda1, exp_read(a1));
            check("rand_rd2", rf.readda2, exp_read(a2));
            tick();
        end

        // Reset mid-operation, between edges, with a write pending
        drive(5'd5, 5'd5, 5'd5, 32'h55, 1'b1);
        #10;
        rst_n = 1'b0;
        clear_model();
        for (int i = 0; i < 32; i++) begin
            rf.readreg1 = 5'(i);
            rf.readreg2 = 5'(31 - i);
            #1;
            check("midrst_rd1", rf.readda1, 32'd0);
            check("midrst_rd2", rf.readda2, 32'd0);
        end
        // Rising edge while reset is held: reset wins over the write
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(5'd5, 5'd31, 5'd0, 32'd0, 1'b0);
        #1;
        check("rstwin_r5", rf.readda1, 32'd0);
        check("rstwin_r31", rf.readda2, 32'd0);

        // Normal operation resumes after reset
        drive(5'd5, 5'd5, 5'd5, 32'h77, 1'b1);
        tick();
        rf.regwrite = 1'b0;
        #1;
        check("post_rst_rd1", rf.readda1, 32'h77);
        check("post_rst_rd2", rf.readda2, exp_read(5'd5));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
